// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset control FSM: fetch/decode/exec/mem/writeback sequencing
// with handshake timeouts, sticky trap flags and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    input  logic        dmem_ack,
    input  logic        branch_taken,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic [1:0]  pc_sel,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        bus_err,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [3:0] TIMEOUT = 4'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] instret_q, instret_d;
    logic [3:0]  wait_q, wait_d;
    logic        illegal_q, illegal_d;
    logic        bus_err_q, bus_err_d;

    logic [4:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_branch, is_load, is_jal, is_jalr, is_lui;
    logic        legal;
    logic        unused_ir;

    assign opc       = ir_q[6:2];
    assign f3        = ir_q[14:12];
    assign f7        = ir_q[31:25];
    assign is_branch = (opc == 5'b11000);
    assign is_load   = (opc == 5'b00000);
    assign is_jal    = (opc == 5'b11011);
    assign is_jalr   = (opc == 5'b11001);
    assign is_lui    = (opc == 5'b01101);
    assign unused_ir = ^ir_q[24:15];

    always_comb begin
        legal = 1'b0;
        if (ir_q[1:0] == 2'b11) begin
            case (opc)
                5'b01100: begin
                    if (f3 == 3'b000 || f3 == 3'b101)
                        legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    else
                        legal = (f7 == 7'b0000000);
                end
                5'b00100: begin
                    if (f3 == 3'b001)
                        legal = (f7 == 7'b0000000);
                    else if (f3 == 3'b101)
                        legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    else
                        legal = 1'b1;
                end
                5'b11000: legal = !(f3 == 3'b010 || f3 == 3'b011);
                5'b00101, 5'b01101, 5'b11011: legal = 1'b1;
                5'b11001: legal = (f3 == 3'b000);
                5'b00000: legal = (f3 == 3'b010);
                default:  legal = 1'b0;
            endcase
        end
    end

    logic       imem_req_c, dmem_req_c, ir_we_c, pc_we_c, rf_we_c;
    logic [1:0] pc_sel_c, wb_sel_c;
    logic       req_pend;
    logic [3:0] wait_inc;

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        instret_d  = instret_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        rf_we_c    = 1'b0;
        pc_sel_c   = 2'd0;
        wb_sel_c   = 2'd0;
        req_pend   = 1'b0;
        wait_inc   = wait_q + 4'd1;

        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_we_c = 1'b1;
                    ir_d    = instr;
                    state_d = S_DECODE;
                end else begin
                    req_pend = 1'b1;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_we_c   = 1'b1;
                    pc_sel_c  = branch_taken ? 2'd1 : 2'd0;
                    instret_d = instret_q + 32'd1;
                    state_d   = S_FETCH;
                end else if (is_load) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                if (dmem_ack)
                    state_d = S_WB;
                else
                    req_pend = 1'b1;
            end
            S_WB: begin
                pc_we_c   = 1'b1;
                rf_we_c   = (ir_q[11:7] != 5'd0);
                pc_sel_c  = is_jal ? 2'd2 : (is_jalr ? 2'd3 : 2'd0);
                wb_sel_c  = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : (is_lui ? 2'd3 : 2'd0));
                instret_d = instret_q + 32'd1;
                state_d   = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase

        // Waiting cycle that reaches the limit abandons the handshake.
        if (req_pend && wait_inc == TIMEOUT) begin
            state_d   = S_TRAP;
            bus_err_d = 1'b1;
        end

        if (state_d != state_q)
            wait_d = 4'd0;
        else if (req_pend)
            wait_d = wait_inc;
        else
            wait_d = wait_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ir_q      <= 32'd0;
            instret_q <= 32'd0;
            wait_q    <= 4'd0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Every output reads zero for as long as reset is held.
    assign imem_req = imem_req_c & ~reset;
    assign dmem_req = dmem_req_c & ~reset;
    assign ir_we    = ir_we_c & ~reset;
    assign pc_we    = pc_we_c & ~reset;
    assign rf_we    = rf_we_c & ~reset;
    assign pc_sel   = reset ? 2'd0 : pc_sel_c;
    assign wb_sel   = reset ? 2'd0 : wb_sel_c;
    assign state    = reset ? 3'd0 : state_q;
    assign illegal  = illegal_q & ~reset;
    assign bus_err  = bus_err_q & ~reset;
    assign instret  = reset ? 32'd0 : instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected output vectors are
// queued with their stimulus and compared as each cycle is played out.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        imem_req, imem_ack = 1'b0;
    logic        dmem_req, dmem_ack = 1'b0;
    logic        branch_taken = 1'b0;
    logic        ir_we, pc_we, rf_we;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  state;
    logic        illegal, bus_err;
    logic [31:0] instret;

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .instr(instr),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .branch_taken(branch_taken),
        .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
        .pc_sel(pc_sel), .wb_sel(wb_sel), .state(state),
        .illegal(illegal), .bus_err(bus_err), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] exp;
        logic        rst;
        logic        iack;
        logic        dack;
        logic        bt;
    } cyc_t;

    cyc_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] n_ret   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] st, input logic ireq, input logic dreq,
                                       input logic irwe, input logic pcwe, input logic rfwe,
                                       input logic [1:0] psel, input logic [1:0] wsel,
                                       input logic ill, input logic berr);
        return {st, ireq, dreq, irwe, pcwe, rfwe, psel, wsel, ill, berr, 2'b00};
    endfunction

    function automatic logic [15:0] observed();
        return {state, imem_req, dmem_req, ir_we, pc_we, rf_we, pc_sel, wb_sel, illegal, bus_err, 2'b00};
    endfunction

    task automatic push(input string tag, input logic [15:0] exp, input logic rst,
                        input logic iack, input logic dack, input logic bt);
        cyc_t c;
        c.tag = tag; c.exp = exp; c.rst = rst; c.iack = iack; c.dack = dack; c.bt = bt;
        sb_q.push_back(c);
    endtask

    task automatic run_queue();
        cyc_t c;
        while (sb_q.size() > 0) begin
            c = sb_q.pop_front();
            @(negedge clk);
            reset = c.rst; imem_ack = c.iack; dmem_ack = c.dack; branch_taken = c.bt;
            #1;
            check(c.tag, {16'd0, observed()}, {16'd0, c.exp});
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++)
            push("reset", mk(3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0), 1'b1, 1'b1, 1'b1, 1'b1);
        run_queue();
        n_ret = 0;
        check("instret_rst", instret, n_ret);
    endtask

    // kind: 0 = writeback instruction, 1 = load, 2 = branch
    task automatic do_instr(input string name, input logic [31:0] word, input int iwait,
                            input int dwait, input logic legal, input int kind, input logic bt,
                            input logic [1:0] psel, input logic [1:0] wsel, input int ntrap);
        logic rd_nz;
        rd_nz = (word[11:7] != 5'd0);
        instr = word;
        for (int i = 0; i < iwait; i++)
            push({name, "_fw"}, mk(3'd0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0), 0, 0, 1, 0);
        push({name, "_fetch"}, mk(3'd0, 1, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0), 0, 1, 0, 0);
        push({name, "_dec"}, mk(3'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0), 0, 1, 1, 1);
        if (!legal) begin
            for (int i = 0; i < ntrap; i++)
                push({name, "_trap"}, mk(3'd5, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0), 0, 1, 1, 1);
        end else if (kind == 2) begin
            push({name, "_exec"}, mk(3'd2, 0, 0, 0, 1, 0, {1'b0, bt}, 2'd0, 0, 0), 0, 0, 0, bt);
        end else begin
            push({name, "_exec"}, mk(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0), 0, 0, 1, 1);
            if (kind == 1) begin
                for (int i = 0; i < dwait; i++)
                    push({name, "_mw"}, mk(3'd3, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0), 0, 1, 0, 0);
                push({name, "_mem"}, mk(3'd3, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0), 0, 0, 1, 0);
            end
            push({name, "_wb"}, mk(3'd4, 0, 0, 0, 1, rd_nz, psel, wsel, 0, 0), 0, 0, 0, 1);
        end
        run_queue();
        if (legal) begin
            n_ret = n_ret + 32'd1;
            @(posedge clk);
            #1;
            check({name, "_instret"}, instret, n_ret);
        end
        $display("[TB] %s instr=%h instret=%0d state=%0d", name, word, instret, state);
    endtask

    initial begin
        do_reset();
        do_instr("addi",   32'h00500093, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0);
        do_instr("lw",     32'h0000A103, 0, 3, 1, 1, 0, 2'd0, 2'd1, 0);
        do_instr("beq_t",  32'h00000063, 0, 0, 1, 2, 1, 2'd0, 2'd0, 0);
        do_instr("beq_nt", 32'h00000063, 1, 0, 1, 2, 0, 2'd0, 2'd0, 0);
        do_instr("jal",    32'h0000006F, 0, 0, 1, 0, 0, 2'd2, 2'd2, 0);
        do_instr("jalr",   32'h000080E7, 0, 0, 1, 0, 0, 2'd3, 2'd2, 0);
        do_instr("lui",    32'h000002B7, 0, 0, 1, 0, 0, 2'd0, 2'd3, 0);
        do_instr("auipc",  32'h00000197, 2, 0, 1, 0, 0, 2'd0, 2'd0, 0);
        do_instr("sub_x0", 32'h40000033, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0);
        do_instr("srai",   32'h4010D093, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0);

        do_instr("sw",     32'h0020A023, 0, 0, 0, 0, 0, 2'd0, 2'd0, 20);
        check("instret_trap", instret, n_ret);
        do_reset();
        do_instr("add_f7", 32'h02000033, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3);
        do_reset();
        do_instr("jalr_f3", 32'h00001067, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3);
        do_reset();
        do_instr("br_f3",  32'h00002063, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3);
        do_reset();
        do_instr("lw_f3",  32'h00001003, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3);
        do_reset();
        do_instr("bad_lo", 32'h00500092, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3);
        do_reset();

        // Fetch never acknowledged: 15 waiting cycles, then a sticky bus error.
        for (int i = 0; i < 15; i++)
            push("to_wait", mk(3'd0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0), 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            push("to_trap", mk(3'd5, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1), 0, i[0], 1, 0);
        run_queue();
        $display("[TB] imem timeout state=%0d bus_err=%0d", state, bus_err);
        do_reset();
        do_instr("addi2",  32'h00500093, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
